// File: rtl/pulse_window_monitor.sv
// Window statistics monitor for a ce-strobed pulse stream: counts rising edges, ones and the
// longest zero run over WINDOW samples, and presents each window result on a valid/ready port.
module pulse_window_monitor #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_ce,
  input  logic             i_pulse_in,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [CNT_W-1:0] o_res_count,
  output logic [CNT_W-1:0] o_res_ones,
  output logic [CNT_W-1:0] o_res_max_gap,
  output logic             o_overrun
);

  localparam int unsigned      IdxW    = $clog2(WINDOW);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(WINDOW - 1);
  localparam logic [IdxW-1:0]  IdxOne  = IdxW'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e r_state, w_state_nxt;

  logic [IdxW-1:0]  r_idx, w_idx_nxt;
  logic             r_prev, w_prev_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_ones, w_ones_nxt;
  logic [CNT_W-1:0] r_run, w_run_nxt;
  logic [CNT_W-1:0] r_maxg, w_maxg_nxt;

  logic             r_res_valid, w_res_valid_nxt;
  logic [CNT_W-1:0] r_res_count, w_res_count_nxt;
  logic [CNT_W-1:0] r_res_ones, w_res_ones_nxt;
  logic [CNT_W-1:0] r_res_gap, w_res_gap_nxt;
  logic             r_overrun, w_overrun_nxt;

  logic             w_sample;
  logic             w_win_end;
  logic [CNT_W-1:0] w_cnt_upd, w_ones_upd, w_run_upd, w_maxg_upd, w_gap_cand;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic b);
    return (b && (a != '1)) ? a + CntOne : a;
  endfunction

  function automatic logic [CNT_W-1:0] max_u(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_en)  w_state_nxt = StRun;
      StRun:   if (!i_en) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // A cycle that drops en discards the window, so its sample never counts.
  assign w_sample  = (r_state == StRun) && i_en && i_ce;
  assign w_win_end = w_sample && (r_idx == IdxLast);

  assign w_ones_upd = sat_inc(r_ones, i_pulse_in);
  assign w_cnt_upd  = sat_inc(r_cnt, i_pulse_in & ~r_prev);
  assign w_run_upd  = i_pulse_in ? '0 : sat_inc(r_run, 1'b1);
  assign w_maxg_upd = i_pulse_in ? max_u(r_maxg, r_run) : r_maxg;
  assign w_gap_cand = max_u(w_maxg_upd, w_run_upd);

  always_comb begin
    w_idx_nxt  = r_idx;
    w_prev_nxt = r_prev;
    w_cnt_nxt  = r_cnt;
    w_ones_nxt = r_ones;
    w_run_nxt  = r_run;
    w_maxg_nxt = r_maxg;
    if ((r_state == StIdle) || !i_en) begin
      // Holding everything at zero outside RUN also clears prev on entry to RUN.
      w_idx_nxt  = '0;
      w_prev_nxt = 1'b0;
      w_cnt_nxt  = '0;
      w_ones_nxt = '0;
      w_run_nxt  = '0;
      w_maxg_nxt = '0;
    end else if (i_ce) begin
      w_prev_nxt = i_pulse_in;
      if (w_win_end) begin
        w_idx_nxt  = '0;
        w_cnt_nxt  = '0;
        w_ones_nxt = '0;
        w_run_nxt  = '0;
        w_maxg_nxt = '0;
      end else begin
        w_idx_nxt  = r_idx + IdxOne;
        w_cnt_nxt  = w_cnt_upd;
        w_ones_nxt = w_ones_upd;
        w_run_nxt  = w_run_upd;
        w_maxg_nxt = w_maxg_upd;
      end
    end
  end

  always_comb begin
    w_res_valid_nxt = r_res_valid;
    w_res_count_nxt = r_res_count;
    w_res_ones_nxt  = r_res_ones;
    w_res_gap_nxt   = r_res_gap;
    w_overrun_nxt   = r_overrun;
    if (w_win_end) begin
      if (!r_res_valid || i_res_ready) begin
        w_res_valid_nxt = 1'b1;
        w_res_count_nxt = w_cnt_upd;
        w_res_ones_nxt  = w_ones_upd;
        w_res_gap_nxt   = w_gap_cand;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_res_valid && i_res_ready) begin
      w_res_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_idx       <= '0;
      r_prev      <= 1'b0;
      r_cnt       <= '0;
      r_ones      <= '0;
      r_run       <= '0;
      r_maxg      <= '0;
      r_res_valid <= 1'b0;
      r_res_count <= '0;
      r_res_ones  <= '0;
      r_res_gap   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_prev      <= w_prev_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ones      <= w_ones_nxt;
      r_run       <= w_run_nxt;
      r_maxg      <= w_maxg_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_count <= w_res_count_nxt;
      r_res_ones  <= w_res_ones_nxt;
      r_res_gap   <= w_res_gap_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign o_res_valid   = r_res_valid;
  assign o_res_count   = r_res_count;
  assign o_res_ones    = r_res_ones;
  assign o_res_max_gap = r_res_gap;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_pulse_window_monitor.sv
// Scoreboard bench for pulse_window_monitor with WINDOW=8: directed windows push expected
// results; a negedge monitor checks every presented result against the queue head.
module tb_pulse_window_monitor;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          i_rst, i_en, i_ce, i_pulse_in, i_res_ready;
  logic          o_res_valid, o_overrun;
  logic [CW-1:0] o_res_count, o_res_ones, o_res_max_gap;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [CW-1:0] ones;
    logic [CW-1:0] gap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  pulse_window_monitor #(
    .WINDOW(W),
    .CNT_W (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_ce         (i_ce),
    .i_pulse_in   (i_pulse_in),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_count  (o_res_count),
    .o_res_ones   (o_res_ones),
    .o_res_max_gap(o_res_max_gap),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic ce, input logic p);
    i_ce       = ce;
    i_pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  // pat is read MSB first: pat[7] is the first sample of the window.
  task automatic feed_window(input logic [7:0] pat, input bit gated);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[7-i]);
      if (i == 7) check("valid_after_window_end", {31'd0, o_res_valid}, 32'd1);
      if (gated) step(1'b0, 1'b1);
    end
  endtask

  task automatic push(input int c, input int o, input int g);
    exp_t e;
    e.cnt  = CW'(c);
    e.ones = CW'(o);
    e.gap  = CW'(g);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {31'd0, o_res_valid}, 32'd0);
    check("rst_count", {16'd0, o_res_count}, 32'd0);
    check("rst_ones", {16'd0, o_res_ones}, 32'd0);
    check("rst_gap", {16'd0, o_res_max_gap}, 32'd0);
    check("rst_overrun", {31'd0, o_overrun}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (o_res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("res_count", {16'd0, o_res_count}, {16'd0, exp_q[0].cnt});
        check("res_ones", {16'd0, o_res_ones}, {16'd0, exp_q[0].ones});
        check("res_max_gap", {16'd0, o_res_max_gap}, {16'd0, exp_q[0].gap});
        if (i_res_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b0; i_en = 1'b0; i_ce = 1'b0; i_pulse_in = 1'b0; i_res_ready = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    check_reset_outputs();

    i_rst = 1'b1;
    i_en  = 1'b1;
    step(1'b0, 1'b0);

    // Basic window: 0,1,1,0,0,0,1,0
    push(2, 3, 3);
    feed_window(8'b01100010, 1'b0);
    step(1'b0, 1'b0);
    check("valid_one_cycle", {31'd0, o_res_valid}, 32'd0);
    check("overrun_basic", {31'd0, o_overrun}, 32'd0);

    // Gated ce with 1s on the ce-low cycles
    push(2, 3, 3);
    feed_window(8'b01100010, 1'b1);
    check("valid_drop_gated", {31'd0, o_res_valid}, 32'd0);

    // All-zero then all-one (prev=0 carried across the boundary)
    push(0, 0, 8);
    feed_window(8'b00000000, 1'b0);
    push(1, 8, 0);
    feed_window(8'b11111111, 1'b0);
    step(1'b0, 1'b0);

    // Backpressure: A held, B dropped, C loaded with ready on its final sample
    i_res_ready = 1'b0;
    push(2, 5, 2);
    feed_window(8'b10011011, 1'b0);
    check("overrun_after_A", {31'd0, o_overrun}, 32'd0);
    feed_window(8'b00000000, 1'b0);
    check("overrun_after_B", {31'd0, o_overrun}, 32'd1);
    push(1, 4, 4);
    for (int i = 0; i < 7; i++) step(1'b1, (i < 4) ? 1'b1 : 1'b0);
    i_res_ready = 1'b1;
    step(1'b1, 1'b0);
    check("valid_stays_C", {31'd0, o_res_valid}, 32'd1);
    check("overrun_sticky", {31'd0, o_overrun}, 32'd1);
    step(1'b0, 1'b0);

    // en drop after 5 samples; ce pulses while IDLE are ignored
    repeat (5) step(1'b1, 1'b1);
    i_en = 1'b0;
    repeat (3) step(1'b1, 1'b1);
    check("no_partial_result", {31'd0, o_res_valid}, 32'd0);
    i_en = 1'b1;
    step(1'b0, 1'b0);
    push(3, 4, 2);
    feed_window(8'b10010110, 1'b0);
    step(1'b0, 1'b0);

    // Mid-window reset with a pending result
    i_res_ready = 1'b0;
    push(1, 8, 0);
    feed_window(8'b11111111, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    i_rst = 1'b0;
    step(1'b0, 1'b0);
    exp_q.delete();
    check_reset_outputs();
    i_rst = 1'b1;
    i_res_ready = 1'b1;
    step(1'b0, 1'b0);
    push(4, 4, 1);
    feed_window(8'b01010101, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_reset_overrun", {31'd0, o_overrun}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_window_monitor.md
# pulse_window_monitor

Downstream consumer of `random_pulse_generator`. Samples the generator's `q` output on the same `ce` strobe that drives the generator, and accumulates statistics over fixed windows of `WINDOW` samples:
- rising-edge count;
- count of samples at 1;
- longest run of 0 samples.

Each completed window's result is presented on a valid/ready output port for a checker or host register bank.

## Interface
- `WINDOW`, default 256: number of ce-qualified samples per window, ≥ 2.
- `CNT_W`, default 16: width of every result field. Must satisfy 2^CNT_W > WINDOW.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset. Sampled on `clk`.
- `en` in 1: monitoring enable. Low = IDLE.
- `ce` in 1: sample strobe, shared with the generator. `pulse_in` is only looked at on cycles where `ce` = 1.
- `pulse_in` in 1: connects to generator `q`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_count` out CNT_W: 0→1 transitions in the window.
- `res_ones` out CNT_W: samples equal to 1.
- `res_max_gap` out CNT_W: longest run of consecutive 0 samples.
- `overrun` out 1: sticky. A window result was dropped.

## Operation
- **States.** IDLE and RUN.
  - IDLE → RUN when `en` = 1.
  - RUN → IDLE when `en` = 0. The partial window is discarded and all accumulators are cleared.
  - A pending result is kept across RUN → IDLE.
- **Accumulators.** The following are updated only when state = RUN and `ce` = 1:
  - sample index `idx` (0..WINDOW-1);
  - previous sample `prev`;
  - `cnt`, `ones`, `run` (current 0-run), `maxg`.
- **Per-sample update.** Let s = `pulse_in`.
  - `ones` += s.
  - `cnt` += (s & ~`prev`).
  - If s = 0: `run` += 1.
  - If s = 1: `maxg` = max(`maxg`, `run`), then `run` = 0.
  - `prev` = s.
- **prev reset.** `prev` is cleared to 0 on entry to RUN. It is not cleared at window boundaries, so an edge that straddles two windows counts in the later window.
- **Window end.** This is the sample with `idx` = WINDOW-1. The candidate result is computed including that sample:
  - count = `cnt` + edge;
  - ones = `ones` + s;
  - max_gap = max(`maxg`, `run` + ~s).
  - The accumulators are then cleared and `idx` wraps to 0, so the next window starts at the next ce sample with no gap.
- **Arithmetic.** All counters saturate at all-ones. Given the width rule on `CNT_W`, saturation is never reached.
- **Output register.**
  - Window end with `res_valid` = 0, or with `res_valid` & `res_ready` in the same cycle: load the candidate and set `res_valid` = 1.
  - Window end with `res_valid` = 1 and `res_ready` = 0: drop the candidate, set `overrun` = 1, and leave the held result unchanged.
  - `res_valid` & `res_ready` with no window end: `res_valid` = 0.
  - The `res_*` fields are stable while `res_valid` = 1.
  - `overrun` clears only on reset.
- **ce in IDLE.** `ce` pulses while IDLE are ignored.

## Timing
- **Reset.** While `rst` = 0 at a clock edge:
  - state = IDLE;
  - `res_valid` = 0; `res_count` = `res_ones` = `res_max_gap` = 0; `overrun` = 0;
  - all accumulators = 0.
- **Reset mid-window or mid-handshake.** The window and any pending result are lost. No output is produced.
- **First sample.** `en` rising at edge N (state becomes RUN). The first sample counted is the first `ce` = 1 cycle at or after N+1.
- **Result latency.** `res_valid` rises at the clock edge that ends the cycle of the final (WINDOW-th) sample, i.e. visible 1 cycle after that sample is presented.
- **Throughput.** The consumer has WINDOW ce-samples of time to accept each result before overrun.
- **No combinational paths** from inputs to outputs.

## Test plan
- **Basic window.** WINDOW=8, `ce`=1 every cycle, `res_ready`=1, pulse pattern 0,1,1,0,0,0,1,0 → `res_valid` for 1 cycle one cycle after the 8th sample; `res_count`=2, `res_ones`=3, `res_max_gap`=3, `overrun`=0.
- **Gated ce.** Same pattern with `ce` every other cycle, and `pulse_in` driven to 1 on the ce-low cycles → identical result (2, 3, 3). `res_valid` follows the 16th cycle.
- **All-zero and all-one windows.** All-zero window → (0, 0, 8). Following all-one window → `res_count`=1 (prev=0 carried), `res_ones`=8, `res_max_gap`=0.
- **Backpressure.** `res_ready`=0 across two window ends → first result held unchanged, `overrun`=1 after the second end. Raise `res_ready` on the same cycle as the third window end → third result loaded and `res_valid` stays 1.
- **en drop.** Deassert `en` after 5 samples, reassert 3 cycles later → no result for the partial window. The next result covers exactly 8 fresh samples.
- **Mid-window reset.** Assert `rst`=0 mid-window with a pending result → all outputs 0 on the next edge. The first post-reset result reflects only post-reset samples.
